bp_resolve_queue: RTL and testbench

//  Update-side counterpart of the fetch-stage branch predictor. Records each prediction made at F in program

---
 rtl/bp_pkg.sv | 18 +
 rtl/bp_fifo.sv | 67 ++++++
 rtl/bp_resolve_queue.sv | 114 +++++++++++
 tb/tb_bp_resolve_queue.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// bp_pkg: types shared by fetch, the predictor and the resolve queue.
//   BPQ_DEPTH   default number of in-flight predicted branches
//   BPQ_PTR_W   pointer width for a queue of BPQ_DEPTH entries
//   bpq_entry_t one recorded prediction {pc, pred_taken, pred_tgt}
package bp_pkg;

   localparam int unsigned BPQ_DEPTH = 8;
   localparam int unsigned BPQ_PTR_W = $clog2(BPQ_DEPTH);

   typedef struct packed {
      logic [31:0] pc;
      logic        pred_taken;
      logic [31:0] pred_tgt;
   } bpq_entry_t;

   localparam int unsigned BPQ_ENTRY_W = $bits(bpq_entry_t);

endpackage

// File: rtl/bp_fifo.sv
// bp_fifo: circular buffer of predicted-branch records.
//   clk, rst     clock, asynchronous active-low reset
//   i_push       write i_wdata at the tail (ignored when full)
//   i_pop        drop the head entry (ignored when empty)
//   i_clear      empty the buffer; overrides push and pop
//   i_wdata      entry to write
//   o_head       oldest entry (meaningless when empty)
//   o_count      entries occupied
//   o_full       count == DEPTH
//   o_empty      count == 0
module bp_fifo
   import bp_pkg::*;
#(
   parameter int unsigned DEPTH = BPQ_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_push,
   input  logic                     i_pop,
   input  logic                     i_clear,
   input  logic [BPQ_ENTRY_W-1:0]   i_wdata,
   output logic [BPQ_ENTRY_W-1:0]   o_head,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_full,
   output logic                     o_empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [BPQ_ENTRY_W-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]       r_wr_ptr;
   logic [PTR_W-1:0]       r_rd_ptr;
   logic [PTR_W:0]         r_count;
   logic                   w_do_push;
   logic                   w_do_pop;

   assign o_full    = (r_count == (PTR_W+1)'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_head    = r_mem[r_rd_ptr];
   assign w_do_push = i_push & ~o_full & ~i_clear;
   assign w_do_pop  = i_pop & ~o_empty & ~i_clear;

   // DEPTH is a power of two, so pointers wrap DEPTH-1 -> 0 by natural overflow.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_clear) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         if (w_do_push && !w_do_pop)      r_count <= r_count + (PTR_W+1)'(1);
         else if (!w_do_push && w_do_pop) r_count <= r_count - (PTR_W+1)'(1);
      end
   end

   // Storage needs no reset: entries are only read while counted as occupied.
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
   end

endmodule

// File: rtl/bp_resolve_queue.sv
// bp_resolve_queue: matches fetch-time branch predictions against EX outcomes in program order,
// trains the predictor and raises a registered redirect on a mispredict.
//   clk, rst              clock, asynchronous active-low reset
//   push_*_F              prediction record from fetch; push_ready_F = not full
//   flush_i               external flush, empties the queue
//   resolve_*_EX          outcome of the oldest in-flight branch
//   upd_valid_o/pc/taken  predictor training strobe (one cycle after resolve)
//   mispredict_o          one-cycle redirect pulse, redirect_pc_o = correct next PC
//   order_err_o           sticky: resolve on empty queue or PC mismatch with head
//   count_o               entries occupied
//   mispred_cnt_o         saturating mispredict count
module bp_resolve_queue
   import bp_pkg::*;
#(
   parameter int unsigned DEPTH = BPQ_DEPTH,
   parameter int unsigned CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push_valid_F,
   output logic                   push_ready_F,
   input  logic [31:0]            push_pc_F,
   input  logic                   push_pred_taken_F,
   input  logic [31:0]            push_pred_tgt_F,
   input  logic                   flush_i,
   input  logic                   resolve_valid_EX,
   input  logic [31:0]            resolve_pc_EX,
   input  logic                   resolve_taken_EX,
   input  logic [31:0]            resolve_tgt_EX,
   output logic                   upd_valid_o,
   output logic [31:0]            upd_pc_o,
   output logic                   upd_taken_o,
   output logic                   mispredict_o,
   output logic [31:0]            redirect_pc_o,
   output logic                   order_err_o,
   output logic [$clog2(DEPTH):0] count_o,
   output logic [CNT_W-1:0]       mispred_cnt_o
);

   bpq_entry_t             w_wr_entry;
   bpq_entry_t             w_head;
   logic [BPQ_ENTRY_W-1:0] w_head_bits;
   logic                   w_full;
   logic                   w_empty;
   logic                   w_resolve;
   logic                   w_mis;
   logic                   w_clear;
   logic [31:0]            w_redirect;

   logic                   r_upd_valid;
   logic [31:0]            r_upd_pc;
   logic                   r_upd_taken;
   logic                   r_mispredict;
   logic [31:0]            r_redirect_pc;
   logic                   r_order_err;
   logic [CNT_W-1:0]       r_mispred_cnt;

   assign w_wr_entry = '{pc: push_pc_F, pred_taken: push_pred_taken_F, pred_tgt: push_pred_tgt_F};
   assign w_head     = bpq_entry_t'(w_head_bits);

   assign w_resolve  = resolve_valid_EX & ~w_empty;
   assign w_mis      = w_resolve & ((w_head.pred_taken != resolve_taken_EX) |
                                    (resolve_taken_EX & (w_head.pred_tgt != resolve_tgt_EX)));
   // A mispredict makes every younger entry wrong-path, so it empties the queue like a flush.
   assign w_clear    = flush_i | w_mis;
   assign w_redirect = resolve_taken_EX ? resolve_tgt_EX : resolve_pc_EX + 32'd4;
   assign push_ready_F = ~w_full;

   bp_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (push_valid_F),
      .i_pop   (w_resolve),
      .i_clear (w_clear),
      .i_wdata (w_wr_entry),
      .o_head  (w_head_bits),
      .o_count (count_o),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // Training uses the resolved PC: equal to head.pc normally, and the resolve_* value
   // is the one to trust when the order check fails.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_upd_valid   <= 1'b0;
         r_upd_pc      <= '0;
         r_upd_taken   <= 1'b0;
         r_mispredict  <= 1'b0;
         r_redirect_pc <= '0;
         r_order_err   <= 1'b0;
         r_mispred_cnt <= '0;
      end else begin
         r_upd_valid   <= w_resolve;
         r_upd_pc      <= w_resolve ? resolve_pc_EX : '0;
         r_upd_taken   <= w_resolve & resolve_taken_EX;
         r_mispredict  <= w_mis;
         r_redirect_pc <= w_mis ? w_redirect : '0;
         if (resolve_valid_EX && (w_empty || (w_head.pc != resolve_pc_EX))) r_order_err <= 1'b1;
         if (w_mis && (r_mispred_cnt != '1)) r_mispred_cnt <= r_mispred_cnt + CNT_W'(1);
      end
   end

   assign upd_valid_o   = r_upd_valid;
   assign upd_pc_o      = r_upd_pc;
   assign upd_taken_o   = r_upd_taken;
   assign mispredict_o  = r_mispredict;
   assign redirect_pc_o = r_redirect_pc;
   assign order_err_o   = r_order_err;
   assign mispred_cnt_o = r_mispred_cnt;

endmodule

// File: tb/tb_bp_resolve_queue.sv
module tb_bp_resolve_queue;

   localparam int DEPTH = 8;
   localparam int CNT_W = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        push_valid_F = 1'b0;
   logic        push_ready_F;
   logic [31:0] push_pc_F = '0;
   logic        push_pred_taken_F = 1'b0;
   logic [31:0] push_pred_tgt_F = '0;
   logic        flush_i = 1'b0;
   logic        resolve_valid_EX = 1'b0;
   logic [31:0] resolve_pc_EX = '0;
   logic        resolve_taken_EX = 1'b0;
   logic [31:0] resolve_tgt_EX = '0;
   logic        upd_valid_o;
   logic [31:0] upd_pc_o;
   logic        upd_taken_o;
   logic        mispredict_o;
   logic [31:0] redirect_pc_o;
   logic        order_err_o;
   logic [$clog2(DEPTH):0] count_o;
   logic [CNT_W-1:0]       mispred_cnt_o;

   bp_resolve_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk               (clk),
      .rst               (rst),
      .push_valid_F      (push_valid_F),
      .push_ready_F      (push_ready_F),
      .push_pc_F         (push_pc_F),
      .push_pred_taken_F (push_pred_taken_F),
      .push_pred_tgt_F   (push_pred_tgt_F),
      .flush_i           (flush_i),
      .resolve_valid_EX  (resolve_valid_EX),
      .resolve_pc_EX     (resolve_pc_EX),
      .resolve_taken_EX  (resolve_taken_EX),
      .resolve_tgt_EX    (resolve_tgt_EX),
      .upd_valid_o       (upd_valid_o),
      .upd_pc_o          (upd_pc_o),
      .upd_taken_o       (upd_taken_o),
      .mispredict_o      (mispredict_o),
      .redirect_pc_o     (redirect_pc_o),
      .order_err_o       (order_err_o),
      .count_o           (count_o),
      .mispred_cnt_o     (mispred_cnt_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic        pt;
      logic [31:0] tgt;
   } ent_t;

   typedef struct {
      int          stamp;
      logic [31:0] pc;
      logic        taken;
      logic        mis;
      logic [31:0] redirect;
   } exp_t;

   // Reference model: in-flight predictions in program order, plus sticky flag and statistics.
   ent_t        mq[$];
   exp_t        sb[$];
   logic        m_err = 1'b0;
   int          m_cnt = 0;
   int          edge_n = 0;
   int          n_tot = 0;
   int          n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h want 0x%08h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // One clock: check architectural state left by the previous edge, then apply new inputs
   // and advance the model to what the next edge must produce.
   task automatic step(input logic pv, input logic [31:0] ppc, input logic ppt,
                       input logic [31:0] ptgt, input logic fl, input logic rv,
                       input logic [31:0] rpc, input logic rt, input logic [31:0] rtg);
      int   sz;
      ent_t h;
      exp_t e;
      logic mis;
      @(posedge clk);
      edge_n++;
      #1;
      sz = mq.size();
      chk("count_o", 32'(count_o), 32'(sz));
      chk("push_ready_F", 32'(push_ready_F), 32'(sz < DEPTH));
      chk("order_err_o", 32'(order_err_o), 32'(m_err));
      chk("mispred_cnt_o", 32'(mispred_cnt_o), 32'(m_cnt));
      push_valid_F = pv; push_pc_F = ppc; push_pred_taken_F = ppt; push_pred_tgt_F = ptgt;
      flush_i = fl;
      resolve_valid_EX = rv; resolve_pc_EX = rpc; resolve_taken_EX = rt; resolve_tgt_EX = rtg;
      mis = 1'b0;
      if (rv && (sz == 0 || mq[0].pc != rpc)) m_err = 1'b1;
      if (rv && sz > 0) begin
         h   = mq.pop_front();
         mis = (h.pt != rt) || (rt && h.tgt != rtg);
         e.stamp    = edge_n + 1;
         e.pc       = rpc;
         e.taken    = rt;
         e.mis      = mis;
         e.redirect = rt ? rtg : rpc + 32'd4;
         sb.push_back(e);
         if (mis && m_cnt < (1 << CNT_W) - 1) m_cnt++;
      end
      if (fl || mis) mq.delete();
      else if (pv && sz < DEPTH) begin
         h.pc = ppc; h.pt = ppt; h.tgt = ptgt;
         mq.push_back(h);
      end
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic push(input logic [31:0] pc, input logic pt, input logic [31:0] tgt);
      step(1, pc, pt, tgt, 0, 0, 0, 0, 0);
   endtask

   task automatic resolve(input logic [31:0] pc, input logic t, input logic [31:0] tgt);
      step(0, 0, 0, 0, 0, 1, pc, t, tgt);
   endtask

   // Monitor: whenever the DUT shows an update, compare it with the oldest expectation.
   logic mon_on = 1'b0;
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst && mon_on) begin
            if (upd_valid_o) begin
               if (sb.size() == 0 || sb[0].stamp != edge_n) begin
                  chk("upd_valid_unexpected", 32'(upd_valid_o), 32'd0);
               end else begin
                  e = sb.pop_front();
                  chk("upd_pc_o", upd_pc_o, e.pc);
                  chk("upd_taken_o", 32'(upd_taken_o), 32'(e.taken));
                  chk("mispredict_o", 32'(mispredict_o), 32'(e.mis));
                  if (e.mis) chk("redirect_pc_o", redirect_pc_o, e.redirect);
               end
            end else begin
               chk("mispredict_idle", 32'(mispredict_o), 32'd0);
               if (sb.size() != 0 && sb[0].stamp <= edge_n) begin
                  chk("upd_valid_missing", 32'(upd_valid_o), 32'd1);
                  void'(sb.pop_front());
               end
            end
         end
      end
   end

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_count_o"}, 32'(count_o), 32'd0);
      chk({tag, "_push_ready_F"}, 32'(push_ready_F), 32'd1);
      chk({tag, "_upd_valid_o"}, 32'(upd_valid_o), 32'd0);
      chk({tag, "_upd_pc_o"}, upd_pc_o, 32'd0);
      chk({tag, "_upd_taken_o"}, 32'(upd_taken_o), 32'd0);
      chk({tag, "_mispredict_o"}, 32'(mispredict_o), 32'd0);
      chk({tag, "_redirect_pc_o"}, redirect_pc_o, 32'd0);
      chk({tag, "_order_err_o"}, 32'(order_err_o), 32'd0);
      chk({tag, "_mispred_cnt_o"}, 32'(mispred_cnt_o), 32'd0);
   endtask

   initial begin
      logic        pv, ppt, fl, rv, rt;
      logic [31:0] ppc, ptgt, rpc, rtg;

      #22;
      check_reset_outputs("reset");
      @(negedge clk);
      rst = 1'b1;
      mon_on = 1'b1;

      // 1: correctly predicted not-taken branch
      push(32'h100, 0, 32'h0);
      resolve(32'h100, 0, 32'h0);
      idle();

      // 2: predicted taken, actually not taken; younger entry squashed
      push(32'h200, 1, 32'h240);
      push(32'h204, 0, 32'h0);
      resolve(32'h200, 0, 32'h0);
      idle();
      idle();

      // 3: target mismatch, then matching target
      push(32'h2f0, 1, 32'h300);
      resolve(32'h2f0, 1, 32'h310);
      push(32'h2f0, 1, 32'h300);
      resolve(32'h2f0, 1, 32'h300);
      idle();

      // 4: fill, overflow push, push+pop while full, drain; repeated so pointers wrap
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < DEPTH + 1; i++) push(32'h400 + 32'(i * 4), 0, 32'h0);
         step(1, 32'h4f0, 0, 32'h0, 0, 1, 32'h400, 0, 32'h0);
         for (int i = 1; i < DEPTH; i++) resolve(32'h400 + 32'(i * 4), 0, 32'h0);
         push(32'h480, 0, 32'h0);
         push(32'h484, 1, 32'h4c0);
         resolve(32'h480, 0, 32'h0);
         resolve(32'h484, 1, 32'h4c0);
         idle();
      end

      // 5: resolve on empty, then PC mismatch with head
      resolve(32'h500, 0, 32'h0);
      push(32'h504, 0, 32'h0);
      resolve(32'h500, 1, 32'h520);
      idle();

      // 6: flush with simultaneous push and resolve, then async reset mid-stream
      push(32'h600, 0, 32'h0);
      push(32'h604, 1, 32'h700);
      push(32'h608, 0, 32'h0);
      step(1, 32'h60c, 0, 32'h0, 1, 1, 32'h600, 0, 32'h0);
      idle();
      push(32'h610, 1, 32'h800);
      push(32'h614, 0, 32'h0);
      step(0, 0, 0, 0, 0, 1, 32'h610, 0, 32'h0);
      #3;
      rst = 1'b0;
      #1;
      check_reset_outputs("midrst");
      mq.delete(); sb.delete(); m_err = 1'b0; m_cnt = 0;
      push_valid_F = 0; flush_i = 0; resolve_valid_EX = 0;
      @(negedge clk);
      rst = 1'b1;

      // Random traffic against the model
      for (int n = 0; n < 1500; n++) begin
         pv   = ($urandom % 3) != 0;
         ppc  = 32'h1000 + {20'd0, 10'($urandom), 2'b00};
         ppt  = 1'($urandom);
         ptgt = {$urandom} & 32'hffff_fffc;
         fl   = ($urandom % 50) == 0;
         if (mq.size() > 0) begin
            rv  = 1'($urandom);
            rpc = (($urandom % 20) != 0) ? mq[0].pc : ppc;
            if (($urandom % 4) != 0) begin
               rt = mq[0].pt; rtg = mq[0].tgt;
            end else begin
               rt  = 1'($urandom);
               rtg = 1'($urandom) ? mq[0].tgt : ({$urandom} | 32'hffff_fffc);
            end
         end else begin
            rv  = ($urandom % 16) == 0;
            rpc = ppc; rt = 1'($urandom); rtg = ptgt;
         end
         step(pv, ppc, ppt, ptgt, fl, rv, rpc, rt, rtg);
      end
      for (int i = 0; i < 4; i++) idle();
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
